// File: rtl/stopwatch_input_conditioner.sv
// Synchronises, debounces and pulse-shapes the raw stopwatch board inputs.
// Optional long-press reset is enabled by defining STOPWATCH_LONG_PRESS_RESET_EN.
module stopwatch_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W = 20
`ifdef STOPWATCH_LONG_PRESS_RESET_EN
  ,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int LP_W = 27
`endif
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Btn_Pause,
  input  logic Btn_Reset,
  input  logic Sw_Sel,
  input  logic Sw_Adj,
  output logic Pause_pulse,
  output logic Run,
  output logic Reset_pulse,
  output logic Sel,
  output logic Adj
);

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 pause, 1 reset, 2 select, 3 adjust.
  logic [3:0]      raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      db;
  logic [DB_W-1:0] cnt [4];

  assign raw = {Sw_Adj, Sw_Sel, Btn_Reset, Btn_Pause};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A flip needs DEBOUNCE_CYCLES consecutive mismatching samples; any match restarts the count.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      db <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_MAX) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Sel <= 1'b0;
      Adj <= 1'b0;
    end else begin
      Sel <= db[2];
      Adj <= db[3];
    end
  end

  typedef enum logic {P_IDLE, P_HELD} pause_state_t;

  pause_state_t pause_state;
  pause_state_t pause_next;
  logic         pause_fire;

  always_comb begin
    pause_next = pause_state;
    pause_fire = 1'b0;
    case (pause_state)
      P_IDLE: begin
        if (db[0]) begin
          pause_next = P_HELD;
          pause_fire = 1'b1;
        end
      end
      P_HELD: begin
        if (!db[0]) pause_next = P_IDLE;
      end
      default: pause_next = P_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pause_state <= P_IDLE;
      Pause_pulse <= 1'b0;
      Run         <= 1'b1;
    end else begin
      pause_state <= pause_next;
      Pause_pulse <= pause_fire;
      Run         <= Run ^ pause_fire;
    end
  end

  typedef enum logic [1:0] {R_IDLE, R_HELD, R_FIRED} reset_state_t;

  reset_state_t reset_state;
  reset_state_t reset_next;
  logic         reset_fire;

`ifdef STOPWATCH_LONG_PRESS_RESET_EN
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES - 1);

  logic [LP_W-1:0] lp;
  logic [LP_W-1:0] lp_next;

  // Only a hold lasting the full long-press time fires; releasing early abandons the press.
  always_comb begin
    reset_next = reset_state;
    reset_fire = 1'b0;
    lp_next    = '0;
    case (reset_state)
      R_IDLE: begin
        if (db[1]) reset_next = R_HELD;
      end
      R_HELD: begin
        if (!db[1]) begin
          reset_next = R_IDLE;
        end else if (lp == LP_MAX) begin
          reset_next = R_FIRED;
          reset_fire = 1'b1;
        end else begin
          lp_next = lp + 1'b1;
        end
      end
      R_FIRED: begin
        if (!db[1]) reset_next = R_IDLE;
      end
      default: reset_next = R_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) lp <= '0;
    else          lp <= lp_next;
  end
`else
  always_comb begin
    reset_next = reset_state;
    reset_fire = 1'b0;
    case (reset_state)
      R_IDLE: begin
        if (db[1]) begin
          reset_next = R_FIRED;
          reset_fire = 1'b1;
        end
      end
      R_HELD: begin
        reset_next = db[1] ? R_FIRED : R_IDLE;
      end
      R_FIRED: begin
        if (!db[1]) reset_next = R_IDLE;
      end
      default: reset_next = R_IDLE;
    endcase
  end
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      reset_state <= R_IDLE;
      Reset_pulse <= 1'b0;
    end else begin
      reset_state <= reset_next;
      Reset_pulse <= reset_fire;
    end
  end

endmodule
